// File: rtl/rv32i_boot_ctrl_pkg.sv
// ============================================================
// rv32i_boot_ctrl_pkg: shared state encodings and defaults
// Rev 1.0
// ============================================================
`default_nettype none

package rv32i_boot_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int DEF_IMEM_WORDS = 32;
    localparam int DEF_ADDR_W     = 5;

    function automatic logic len_legal(input int len, input int words);
        return (len >= 1) && (len <= words);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_boot_ctrl_byte_word_packer.sv
// ============================================================
// byte_word_packer: little-endian byte-to-word assembly
// Rev 1.0
// ============================================================
`default_nettype none

module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [1:0]  byte_idx,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [23:0] lanes;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx   <= 2'd0;
            lanes      <= 24'd0;
            word_ready <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_ready <= 1'b0;
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    lanes[7:0]   <= data;
                    2'd1:    lanes[15:8]  <= data;
                    2'd2:    lanes[23:16] <= data;
                    default: begin
                        word       <= {data, lanes};
                        word_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_boot_ctrl.sv
// ============================================================
// rv32i_boot_ctrl: load/run sequencer for the single-cycle RV32I core
// Rev 1.0
// ============================================================
`default_nettype none

module rv32i_boot_ctrl
    import rv32i_boot_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_CYCLES = 1000,
    parameter int CYC_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    input  logic [31:0]       core_pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              len_err,
    output logic [CYC_W-1:0]  run_cycles
);

    localparam logic [CYC_W-1:0] BUDGET_LAST = CYC_W'(MAX_CYCLES - 1);

    logic [1:0]        state;
    logic [ADDR_W:0]   len_m1;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       pc_prev;
    logic              armed;

    logic              accept;
    logic              idle_or_done;
    logic              start_ok;
    logic              start_bad;
    logic              last_word;
    logic              halt_hit;
    logic              budget_hit;
    logic [1:0]        byte_idx;
    logic              word_ready;
    logic [31:0]       word;

    assign accept       = rx_valid & rx_ready;
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok     = start && idle_or_done && len_legal(int'(load_len), IMEM_WORDS);
    assign start_bad    = start && idle_or_done && !len_legal(int'(load_len), IMEM_WORDS);
    assign last_word    = ({1'b0, word_idx} == len_m1);
    assign halt_hit     = armed && (core_pc == pc_prev);
    assign budget_hit   = (run_cycles == BUDGET_LAST);

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .accept     (accept),
        .data       (rx_data),
        .byte_idx   (byte_idx),
        .word_ready (word_ready),
        .word       (word)
    );

    assign imem_we    = word_ready;
    assign imem_wdata = word;
    assign imem_waddr = word_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            core_reset <= 1'b1;
            rx_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            len_err    <= 1'b0;
            run_cycles <= '0;
            word_idx   <= '0;
            len_m1     <= '0;
            pc_prev    <= 32'd0;
            armed      <= 1'b0;
        end else begin
            pc_prev <= core_pc;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state      <= ST_LOAD;
                        len_m1     <= load_len - 1'b1;
                        len_err    <= 1'b0;
                        core_reset <= 1'b1;
                        rx_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        run_cycles <= '0;
                        word_idx   <= '0;
                        armed      <= 1'b0;
                    end else if (start_bad) begin
                        len_err <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Words complete in order, so word_idx already names the word being filled.
                    if (accept && (byte_idx == 2'd3) && last_word) begin
                        rx_ready <= 1'b0;
                    end
                    if (word_ready) begin
                        word_idx <= word_idx + 1'b1;
                        if (last_word) begin
                            state      <= ST_RUN;
                            core_reset <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    armed <= 1'b1;
                    if (halt_hit) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                        armed   <= 1'b0;
                    end else if (budget_hit) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        armed   <= 1'b0;
                    end else if (run_cycles != '1) begin
                        run_cycles <= run_cycles + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
